// File: rtl/alu_pkg.sv
// Shared opcodes, FSM state encoding and defaults for the ALU command sequencer.
// Imported by the core, the sequencer and the bus interface.
package alu_pkg;

    localparam int N_ALU_DEF = 4;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_SHL = 4'b0010;
    localparam logic [3:0] OP_SHR = 4'b0011;
    localparam logic [3:0] OP_EQ  = 4'b0100;
    localparam logic [3:0] OP_GT  = 4'b0101;
    localparam logic [3:0] OP_LT  = 4'b0110;
    localparam logic [3:0] OP_MUL = 4'b0111;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        MUL  = 2'd2,
        RESP = 2'd3
    } alu_state_t;

    typedef struct packed {
        logic of;
        logic zero;
        logic err;
    } alu_flags_t;

endpackage

// File: rtl/alu_cmd_seq_if.sv
// Command/response bus of the ALU sequencer: valid/ready command channel in,
// valid/ready response channel out.
interface alu_cmd_seq_if #(
    parameter int N_ALU = alu_pkg::N_ALU_DEF
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_op;
    logic [N_ALU-1:0] cmd_a;
    logic [N_ALU-1:0] cmd_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [N_ALU-1:0] rsp_dout;
    logic             rsp_of;
    logic             rsp_zero;
    logic             rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_dout, rsp_of, rsp_zero, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_dout, rsp_of, rsp_zero, rsp_err
    );

endinterface

// File: rtl/alu_core.sv
// Single-cycle ALU datapath: add/sub/shift/compare, illegal-op detection.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs, MUL is left to the sequencer.
module alu_core
    import alu_pkg::*;
#(
    parameter int N_ALU = N_ALU_DEF
) (
    input  logic [3:0]       op,
    input  logic [N_ALU-1:0] a,
    input  logic [N_ALU-1:0] b,
    output logic [N_ALU-1:0] dout,
    output logic             of,
    output logic             zero,
    output logic             err
);

    logic [N_ALU:0] wide;
    logic           big_shift;

    // Shift amounts at or beyond the word width flush the result to zero.
    assign big_shift = ({1'b0, b} >= (N_ALU+1)'(N_ALU));

    always_comb begin
        dout = '0;
        of   = 1'b0;
        zero = 1'b0;
        err  = 1'b0;
        wide = '0;
        case (op)
            OP_ADD: begin
                wide = {1'b0, a} + {1'b0, b};
                dout = wide[N_ALU-1:0];
                of   = wide[N_ALU];
            end
            OP_SUB: begin
                wide = {1'b0, a} - {1'b0, b};
                dout = wide[N_ALU-1:0];
                of   = wide[N_ALU];
            end
            OP_SHL: dout = big_shift ? '0 : (a << b);
            OP_SHR: dout = big_shift ? '0 : (a >> b);
            OP_EQ:  zero = (a == b);
            OP_GT:  zero = (a > b);
            OP_LT:  zero = (a < b);
            OP_MUL: dout = '0;
            default: begin
                err  = 1'b1;
                dout = '1;
            end
        endcase
    end

endmodule

// File: rtl/alu_cmd_seq.sv
// Accepts one ALU command at a time, computes it, holds the response until taken.
// Latency: 2 cycles for single-cycle ops, N_ALU+1 for MUL (shift-and-add).
// Backpressure: cmd_ready only in IDLE; response held stable until rsp_ready.
module alu_cmd_seq
    import alu_pkg::*;
#(
    parameter int N_ALU = N_ALU_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    alu_cmd_seq_if.slave bus,
    output logic         busy,
    output logic [7:0]   err_cnt
);

    localparam int             CW       = (N_ALU > 1) ? $clog2(N_ALU) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(N_ALU - 1);

    alu_state_t         state;
    logic [3:0]         op_q;
    logic [N_ALU-1:0]   a_q;
    logic [N_ALU-1:0]   b_q;
    logic [CW-1:0]      bit_cnt;
    logic [2*N_ALU-1:0] acc;
    logic [2*N_ALU-1:0] addend;
    logic [2*N_ALU-1:0] acc_next;

    logic [N_ALU-1:0]   core_dout;
    logic               core_of;
    logic               core_zero;
    logic               core_err;

    logic [N_ALU-1:0]   rsp_dout_q;
    alu_flags_t         rsp_flags_q;
    logic               cmd_ready_q;
    logic               rsp_valid_q;

    alu_core #(
        .N_ALU (N_ALU)
    ) u_core (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .dout (core_dout),
        .of   (core_of),
        .zero (core_zero),
        .err  (core_err)
    );

    // One partial product per cycle, selected by the current multiplier bit.
    always_comb begin
        addend = '0;
        if (b_q[bit_cnt]) begin
            addend = {{N_ALU{1'b0}}, a_q} << bit_cnt;
        end
        acc_next = acc + addend;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            bit_cnt     <= '0;
            acc         <= '0;
            rsp_dout_q  <= '0;
            rsp_flags_q <= '0;
            cmd_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            busy        <= 1'b0;
            err_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        op_q        <= bus.cmd_op;
                        a_q         <= bus.cmd_a;
                        b_q         <= bus.cmd_b;
                        bit_cnt     <= '0;
                        acc         <= '0;
                        cmd_ready_q <= 1'b0;
                        busy        <= 1'b1;
                        state       <= (bus.cmd_op == OP_MUL) ? MUL : EXEC;
                    end
                end
                EXEC: begin
                    rsp_dout_q  <= core_dout;
                    rsp_flags_q <= '{of: core_of, zero: core_zero, err: core_err};
                    if (core_err && (err_cnt != 8'hFF)) begin
                        err_cnt <= err_cnt + 8'd1;
                    end
                    rsp_valid_q <= 1'b1;
                    state       <= RESP;
                end
                MUL: begin
                    acc     <= acc_next;
                    bit_cnt <= bit_cnt + 1'b1;
                    if (bit_cnt == CNT_LAST) begin
                        rsp_dout_q  <= acc_next[N_ALU-1:0];
                        rsp_flags_q <= '{of: |acc_next[2*N_ALU-1:N_ALU], zero: 1'b0, err: 1'b0};
                        rsp_valid_q <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cmd_ready_q <= 1'b1;
                        busy        <= 1'b0;
                        state       <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_dout  = rsp_dout_q;
    assign bus.rsp_of    = rsp_flags_q.of;
    assign bus.rsp_zero  = rsp_flags_q.zero;
    assign bus.rsp_err   = rsp_flags_q.err;

endmodule

// File: tb/tb_alu_cmd_seq.sv
// Directed-vector bench for alu_cmd_seq with hand-computed expectations.
module tb_alu_cmd_seq;
    import alu_pkg::*;

    logic       clk;
    logic       rst_n;
    logic       busy;
    logic [7:0] err_cnt;

    int checks   = 0;
    int failures = 0;

    alu_cmd_seq_if #(.N_ALU(4)) bus ();

    alu_cmd_seq #(.N_ALU(4)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .busy    (busy),
        .err_cnt (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] dout;
        logic [2:0] flg;   // {of, zero, err}
        int         lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic add_vec(input string name, input logic [3:0] op, input logic [3:0] a,
                           input logic [3:0] b, input logic [3:0] dout, input logic [2:0] flg,
                           input int lat);
        vec_t v;
        v.name = name; v.op = op; v.a = a; v.b = b; v.dout = dout; v.flg = flg; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Called #1 after a rising edge with the DUT idle; returns #1 after the handshake edge.
    task automatic run_op(input string name, input logic [3:0] op, input logic [3:0] a,
                          input logic [3:0] b, input bit early,
                          output logic [3:0] dout, output logic [2:0] flg, output int lat);
        int guard;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_valid = 1'b1;
        bus.rsp_ready = early;
        guard = 0;
        while (!bus.cmd_ready && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        check_eq({name, "_accept"}, 32'(guard < 20), 32'd1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check_eq({name, "_busy"}, busy, 1'b1);
        check_eq({name, "_cmd_rdy_lo"}, bus.cmd_ready, 1'b0);
        lat = 1;
        while (!bus.rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        dout = bus.rsp_dout;
        flg  = {bus.rsp_of, bus.rsp_zero, bus.rsp_err};
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check_eq({name, "_rsp_done"}, bus.rsp_valid, 1'b0);
        check_eq({name, "_cmd_rdy_hi"}, bus.cmd_ready, 1'b1);
    endtask

    task automatic check_idle_outputs(input string name);
        check_eq({name, "_cmd_ready"}, bus.cmd_ready, 1'b1);
        check_eq({name, "_rsp_valid"}, bus.rsp_valid, 1'b0);
        check_eq({name, "_rsp_dout"}, bus.rsp_dout, 4'h0);
        check_eq({name, "_flags"}, {bus.rsp_of, bus.rsp_zero, bus.rsp_err}, 3'b000);
        check_eq({name, "_busy"}, busy, 1'b0);
        check_eq({name, "_err_cnt"}, err_cnt, 8'd0);
    endtask

    initial begin
        logic [3:0] d;
        logic [2:0] f;
        int         lat;
        int         seen;

        rst_n         = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 4'h0;
        bus.cmd_a     = 4'h0;
        bus.cmd_b     = 4'h0;
        bus.rsp_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;

        add_vec("add_ovf",  OP_ADD, 4'hF, 4'h1, 4'h0, 3'b100, 2);
        add_vec("add",      OP_ADD, 4'h2, 4'h3, 4'h5, 3'b000, 2);
        add_vec("sub_brw",  OP_SUB, 4'h3, 4'h5, 4'hE, 3'b100, 2);
        add_vec("sub",      OP_SUB, 4'h9, 4'h4, 4'h5, 3'b000, 2);
        add_vec("eq_t",     OP_EQ,  4'h7, 4'h7, 4'h0, 3'b010, 2);
        add_vec("eq_f",     OP_EQ,  4'h7, 4'h6, 4'h0, 3'b000, 2);
        add_vec("gt_t",     OP_GT,  4'h5, 4'h3, 4'h0, 3'b010, 2);
        add_vec("gt_f",     OP_GT,  4'h3, 4'h5, 4'h0, 3'b000, 2);
        add_vec("lt_t",     OP_LT,  4'h3, 4'h5, 4'h0, 3'b010, 2);
        add_vec("lt_eq",    OP_LT,  4'h5, 4'h5, 4'h0, 3'b000, 2);
        add_vec("shl",      OP_SHL, 4'h3, 4'h1, 4'h6, 3'b000, 2);
        add_vec("shl_drop", OP_SHL, 4'h9, 4'h1, 4'h2, 3'b000, 2);
        add_vec("shl_3",    OP_SHL, 4'h1, 4'h3, 4'h8, 3'b000, 2);
        add_vec("shl_big",  OP_SHL, 4'h1, 4'h4, 4'h0, 3'b000, 2);
        add_vec("shr",      OP_SHR, 4'h8, 4'h3, 4'h1, 3'b000, 2);
        add_vec("shr_2",    OP_SHR, 4'hC, 4'h2, 4'h3, 3'b000, 2);
        add_vec("shr_big",  OP_SHR, 4'hF, 4'h9, 4'h0, 3'b000, 2);
        add_vec("mul_4x5",  OP_MUL, 4'h4, 4'h5, 4'h4, 3'b100, 5);
        add_vec("mul_3x3",  OP_MUL, 4'h3, 4'h3, 4'h9, 3'b000, 5);
        add_vec("mul_fxf",  OP_MUL, 4'hF, 4'hF, 4'h1, 3'b100, 5);
        add_vec("mul_0x7",  OP_MUL, 4'h0, 4'h7, 4'h0, 3'b000, 5);
        add_vec("mul_2x7",  OP_MUL, 4'h2, 4'h7, 4'hE, 3'b000, 5);

        // Every third vector has rsp_ready already high when the response appears.
        foreach (vecs[i]) begin
            run_op(vecs[i].name, vecs[i].op, vecs[i].a, vecs[i].b, (i % 3) == 2, d, f, lat);
            check_eq({vecs[i].name, "_dout"}, d, vecs[i].dout);
            check_eq({vecs[i].name, "_flags"}, f, vecs[i].flg);
            check_eq({vecs[i].name, "_lat"}, lat, vecs[i].lat);
        end
        check_eq("legal_err_cnt", err_cnt, 8'd0);

        run_op("ill_1000", 4'b1000, 4'h1, 4'h2, 1'b0, d, f, lat);
        check_eq("ill_dout", d, 4'hF);
        check_eq("ill_flags", f, 3'b001);
        check_eq("ill_lat", lat, 2);
        check_eq("ill_err_cnt1", err_cnt, 8'd1);
        run_op("add_after_ill", OP_ADD, 4'h1, 4'h1, 1'b0, d, f, lat);
        check_eq("add_after_ill_cnt", err_cnt, 8'd1);
        for (int k = 0; k < 255; k++) begin
            run_op("ill_loop", 4'b1000 | 4'(k % 8), 4'(k), 4'h3, 1'b1, d, f, lat);
        end
        check_eq("ill_sat_256", err_cnt, 8'd255);
        run_op("ill_extra", 4'b1111, 4'h0, 4'h0, 1'b0, d, f, lat);
        check_eq("ill_sat_257", err_cnt, 8'd255);
        check_eq("ill_extra_dout", d, 4'hF);

        // Backpressure: response held 3 cycles while a second command waits.
        bus.cmd_op = OP_ADD; bus.cmd_a = 4'h2; bus.cmd_b = 4'h3;
        bus.cmd_valid = 1'b1; bus.rsp_ready = 1'b0;
        @(posedge clk); #1;
        bus.cmd_op = OP_SUB; bus.cmd_a = 4'h9; bus.cmd_b = 4'h2;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            check_eq("bp_rsp_valid", bus.rsp_valid, 1'b1);
            check_eq("bp_dout", bus.rsp_dout, 4'h5);
            check_eq("bp_flags", {bus.rsp_of, bus.rsp_zero, bus.rsp_err}, 3'b000);
            check_eq("bp_cmd_ready", bus.cmd_ready, 1'b0);
            check_eq("bp_busy", busy, 1'b1);
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check_eq("bp_hs_valid", bus.rsp_valid, 1'b0);
        check_eq("bp_hs_cmd_ready", bus.cmd_ready, 1'b1);
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check_eq("bp_second_accept", busy, 1'b1);
        @(posedge clk); #1;
        check_eq("bp_second_valid", bus.rsp_valid, 1'b1);
        check_eq("bp_second_dout", bus.rsp_dout, 4'h7);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;

        // Reset pulse in the middle of a multiply.
        bus.cmd_op = OP_MUL; bus.cmd_a = 4'h4; bus.cmd_b = 4'h5; bus.cmd_valid = 1'b1;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk); #1;
        check_eq("mid_mul_busy", busy, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        check_eq("abort_acc", dut.acc, 8'h00);
        check_eq("abort_cnt", dut.bit_cnt, 2'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid) seen++;
            if (i == 0) check_eq("abort_cmd_ready", bus.cmd_ready, 1'b1);
        end
        check_eq("abort_no_rsp", seen, 0);
        run_op("post_rst_add", OP_ADD, 4'h1, 4'h1, 1'b0, d, f, lat);
        check_eq("post_rst_dout", d, 4'h2);
        check_eq("post_rst_flags", f, 3'b000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
